cell_video_scanout: RTL and testbench
=====================================

Name: cell_video_scanout

Overview:
- Downstream consumer of the cell array's per-cell nextVideo outputs.
- On each end-of-generation strobe it snapshots the whole grid's video registers into a shadow frame buffer.
- It then streams the frame out as a row-major pixel stream with valid/ready handshake toward the display/host link.
- A second (pending) buffer decouples generation rate from drain rate; overrun frames are counted, never corrupt an in-flight frame.

Parameters:
- WIDTH, 8, grid columns (X extent of cell array)
- HEIGHT, 8, grid rows (Y extent)
- VALUE_W, 8, bits per video value; equals the width of isa::value_t
- XW, $clog2(WIDTH) (min 1), column index width, derived
- YW, $clog2(HEIGHT) (min 1), row index width, derived

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- video_in  in  WIDTH*HEIGHT*VALUE_W  flattened nextVideo of all cells; cell (x,y) at bits [(y*WIDTH+x)*VALUE_W +: VALUE_W]
- frame_done  in  1  one-cycle strobe: generation complete, video_in stable this cycle
- px_data  out  VALUE_W  pixel value
- px_x  out  XW  pixel column
- px_y  out  YW  pixel row
- px_last  out  1  high with final pixel (WIDTH-1,HEIGHT-1) of a frame
- px_valid  out  1  pixel beat valid
- px_ready  in  1  consumer accepts beat
- busy  out  1  streaming or pending frame held
- drop_count  out  16  frames overwritten in pending buffer, saturating

Behaviour:
- Reset (rst low, async): state IDLE; px_valid=0, px_data=0, px_x=0, px_y=0, px_last=0, busy=0, drop_count=0, pending_valid=0. Buffer contents undefined; never emitted before a capture.
- FSM: IDLE, STREAM.
- IDLE + frame_done: capture video_in into active buffer at that edge; next cycle STREAM, px_valid=1, coords (0,0). Latency strobe->first beat valid: 1 cycle.
- STREAM: px_data/px_x/px_y/px_last registered, stable while px_valid && !px_ready (AXI-style; valid never drops without handshake).
- Beat transfers on px_valid && px_ready. Advance x; on x==WIDTH-1 wrap x to 0, y+1. Zero-bubble: next beat valid in following cycle.
- Last beat transferred: if pending_valid, copy pending to active, clear pending_valid, restart at (0,0) with px_valid held 1 (no idle cycle); else IDLE, px_valid=0.
- STREAM + frame_done: capture into pending buffer. If pending_valid already 1, overwrite it and increment drop_count (saturate at 16'hFFFF). Set pending_valid=1.
- frame_done in the same cycle as the final handshake: old pending (if any) moves to active; new capture goes to pending; no drop counted. If no old pending, the new capture goes directly to active and streaming restarts at (0,0) next cycle.
- busy = (state==STREAM) || pending_valid.
- Reset asserted mid-frame: stream aborts immediately, px_valid drops asynchronously, pending discarded.
- Index arithmetic: offset = (y*WIDTH+x)*VALUE_W; the mux is purely combinational from the registered coords.

Decomposition:
- isa package: reuse value_t; add scan_coord helpers only if shared with cell array generation.
- Sub-module video_frame_buffer: holds the active and pending registers, capture/promote controls, and a read mux on (x,y).
- Top: FSM, counters, drop accounting, output registers.

Test Plan:
- 2x2 grid, values {0x11,0x22,0x33,0x44}, frame_done, px_ready=1 -> beats 0x11(0,0),0x22(1,0),0x33(0,1),0x44(1,1) on consecutive cycles, px_last only on 4th, then IDLE.
- Same frame, px_ready toggled 1,0,0,1,... -> px_data/coords held during stalls, no beat lost or duplicated.
- frame_done A, then B mid-stream, ready=1 -> A's 4 beats then B's 4 back-to-back with no gap, drop_count=0.
- frame_done A, then B and C during A, ready=0 -> after release stream A then C; drop_count=1.
- frame_done coincident with final handshake of A, no pending -> new frame starts at (0,0) next cycle, drop_count unchanged.
- rst low mid-frame (beat 2 of 4) -> px_valid=0 immediately, busy=0; after release, no output until next frame_done.

Source files
------------

// File: rtl/cell_video_scanout_pkg.sv
// Shared types and helpers for the cell-array video scanout path.
//   value_t      : one cell's video value
//   scan_state_t : scanout FSM encoding
//   idx_w()      : index width for an extent, never less than one bit
package cell_video_scanout_pkg;

  typedef logic [7:0] value_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } scan_state_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_video_scanout_video_frame_buffer.sv
// Active and pending frame snapshots plus a combinational pixel read mux.
// Ports:
//   clk         : system clock
//   video_in    : flattened grid video, cell (x,y) at [(y*WIDTH+x)*VALUE_W +: VALUE_W]
//   cap_active  : load video_in into the active frame
//   promote     : copy the pending frame into the active frame
//   cap_pending : load video_in into the pending frame
//   rd_x, rd_y  : read coordinates into the active frame
//   rd_data     : active frame value at (rd_x, rd_y)
// Contents are unreset on purpose; the scanout never presents a pixel
// before a capture has happened.
module video_frame_buffer
  import cell_video_scanout_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int VALUE_W = 8,
  parameter int XW      = idx_w(WIDTH),
  parameter int YW      = idx_w(HEIGHT)
) (
  input  logic                              clk,
  input  logic [WIDTH*HEIGHT*VALUE_W-1:0]   video_in,
  input  logic                              cap_active,
  input  logic                              promote,
  input  logic                              cap_pending,
  input  logic [XW-1:0]                     rd_x,
  input  logic [YW-1:0]                     rd_y,
  output logic [VALUE_W-1:0]                rd_data
);

  logic [VALUE_W-1:0] active  [HEIGHT][WIDTH];
  logic [VALUE_W-1:0] pending [HEIGHT][WIDTH];

  // A direct capture wins over a promote; the controller never asks for both.
  always_ff @(posedge clk) begin
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        if (cap_active) begin
          active[y][x] <= video_in[(y*WIDTH+x)*VALUE_W +: VALUE_W];
        end else if (promote) begin
          active[y][x] <= pending[y][x];
        end
        if (cap_pending) begin
          pending[y][x] <= video_in[(y*WIDTH+x)*VALUE_W +: VALUE_W];
        end
      end
    end
  end

  assign rd_data = active[rd_y][rd_x];

endmodule

// File: rtl/cell_video_scanout.sv
// Snapshots the cell array's video on each end-of-generation strobe and
// streams it row-major over a valid/ready pixel link. A pending frame
// buffer absorbs one extra generation; further overruns overwrite it and
// are counted.
// Ports:
//   clk, rst (async, active-low)
//   video_in, frame_done           : grid video and its capture strobe
//   px_data, px_x, px_y, px_last   : pixel beat payload
//   px_valid, px_ready             : beat handshake
//   busy                           : streaming or a pending frame held
//   drop_count                     : saturating count of overwritten pending frames
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | no frame in flight, waiting for frame_done
// ST_STREAM | presenting active frame beats at (x_q, y_q)
module cell_video_scanout
  import cell_video_scanout_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 8,
  parameter int VALUE_W = 8,
  parameter int XW      = idx_w(WIDTH),
  parameter int YW      = idx_w(HEIGHT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH*HEIGHT*VALUE_W-1:0]   video_in,
  input  logic                              frame_done,
  output logic [VALUE_W-1:0]                px_data,
  output logic [XW-1:0]                     px_x,
  output logic [YW-1:0]                     px_y,
  output logic                              px_last,
  output logic                              px_valid,
  input  logic                              px_ready,
  output logic                              busy,
  output logic [15:0]                       drop_count
);

  scan_state_t        state_q, state_n;
  logic [XW-1:0]      x_q, x_n;
  logic [YW-1:0]      y_q, y_n;
  logic               pend_q, pend_n;
  logic [15:0]        drop_q, drop_n;
  logic               cap_active, cap_pending, promote;
  logic               fire, at_end;
  logic [VALUE_W-1:0] rd_data;

  video_frame_buffer #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .VALUE_W (VALUE_W),
    .XW      (XW),
    .YW      (YW)
  ) u_fb (
    .clk         (clk),
    .video_in    (video_in),
    .cap_active  (cap_active),
    .promote     (promote),
    .cap_pending (cap_pending),
    .rd_x        (x_q),
    .rd_y        (y_q),
    .rd_data     (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      pend_q  <= pend_n;
      drop_q  <= drop_n;
    end
  end

  assign at_end = (x_q == XW'(WIDTH-1)) && (y_q == YW'(HEIGHT-1));
  assign fire   = (state_q == ST_STREAM) && px_ready;

  always_comb begin
    state_n     = state_q;
    x_n         = x_q;
    y_n         = y_q;
    pend_n      = pend_q;
    drop_n      = drop_q;
    cap_active  = 1'b0;
    cap_pending = 1'b0;
    promote     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          cap_active = 1'b1;
          state_n    = ST_STREAM;
          x_n        = '0;
          y_n        = '0;
        end
      end

      ST_STREAM: begin
        if (fire && at_end) begin
          x_n = '0;
          y_n = '0;
          if (pend_q) begin
            // Old pending moves up; a coincident strobe refills pending
            // without counting a drop.
            promote     = 1'b1;
            cap_pending = frame_done;
            pend_n      = frame_done;
          end else if (frame_done) begin
            cap_active = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          if (frame_done) begin
            cap_pending = 1'b1;
            pend_n      = 1'b1;
            if (pend_q && (drop_q != DROP_MAX)) begin
              drop_n = drop_q + 16'd1;
            end
          end
          if (fire) begin
            if (x_q == XW'(WIDTH-1)) begin
              x_n = '0;
              y_n = y_q + 1'b1;
            end else begin
              x_n = x_q + 1'b1;
            end
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Valid follows the state register directly so reset drops it at once;
  // data is forced to zero whenever no beat is presented.
  assign px_valid   = (state_q == ST_STREAM);
  assign px_data    = px_valid ? rd_data : '0;
  assign px_x       = x_q;
  assign px_y       = y_q;
  assign px_last    = px_valid && at_end;
  assign busy       = px_valid || pend_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_cell_video_scanout.sv
module tb_cell_video_scanout;
  localparam int W  = 2;
  localparam int H  = 2;
  localparam int VW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [W*H*VW-1:0] video_in = '0;
  logic              frame_done = 1'b0;
  logic              px_ready = 1'b0;
  logic [VW-1:0]     px_data;
  logic              px_x;
  logic              px_y;
  logic              px_last;
  logic              px_valid;
  logic              busy;
  logic [15:0]       drop_count;

  int checks = 0;
  int passed = 0;
  logic [10:0] exp_q[$];

  cell_video_scanout #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .VALUE_W (VW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .video_in   (video_in),
    .frame_done (frame_done),
    .px_data    (px_data),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_last    (px_last),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected beat = {data, x, y, last}; cell index i = y*W + x.
  task automatic push_frame(input logic [W*H*VW-1:0] f);
    for (int i = 0; i < W*H; i++) begin
      logic [VW-1:0] d;
      d = f[i*VW +: VW];
      exp_q.push_back({d, 1'(i % W), 1'(i / W), (i == W*H-1)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W*H*VW-1:0] f, input bit expect_stream);
    video_in   = f;
    frame_done = 1'b1;
    if (expect_stream) push_frame(f);
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (px_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard monitor: every presented beat must match the queue head,
  // including on stalled cycles; the head is retired on handshake.
  always @(negedge clk) begin
    if (rst && px_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got data %0h at (%0d,%0d) with nothing expected",
                 px_data, px_x, px_y);
      end else begin
        check("beat", {21'd0, px_data, px_x, px_y, px_last}, {21'd0, exp_q[0]});
        if (px_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [31:0] FA = 32'h44332211;
  localparam logic [31:0] FB = 32'h88776655;
  localparam logic [31:0] FC = 32'hCCBBAA99;
  localparam logic [31:0] FD = 32'h0F0E0D0C;
  localparam logic [31:0] FF = 32'hA5B6C7D8;
  localparam logic [31:0] FG = 32'h13572468;

  initial begin
    int n;
    logic [3:0] pat;

    // Reset state
    #1;
    check("rst_valid", px_valid, 0);
    check("rst_data", px_data, 0);
    check("rst_x", px_x, 0);
    check("rst_y", px_y, 0);
    check("rst_last", px_last, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single frame, ready held high: 4 back-to-back beats then idle.
    px_ready = 1'b1;
    strobe(FA, 1);
    check("s1_first_valid", px_valid, 1);
    wait_idle(n);
    check("s1_beats", n, 4);
    check("s1_busy", busy, 0);

    // Same frame with ready pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    strobe(FA, 1);
    n = 0;
    while (px_valid && n < 100) begin
      px_ready = pat[n % 4];
      tick();
      n++;
    end
    check("s2_cycles", n, 8);
    px_ready = 1'b1;

    // Second frame mid-stream streams directly after the first.
    strobe(FA, 1);
    tick();
    strobe(FB, 1);
    check("s3_busy", busy, 1);
    wait_idle(n);
    check("s3_cycles", n, 6);
    check("s3_drop", drop_count, 0);

    // Two frames during a stalled stream: B is overwritten by C.
    px_ready = 1'b0;
    strobe(FA, 1);
    strobe(FB, 0);
    strobe(FC, 1);
    check("s4_drop", drop_count, 1);
    check("s4_busy", busy, 1);
    px_ready = 1'b1;
    wait_idle(n);
    check("s4_cycles", n, 8);
    check("s4_busy_end", busy, 0);

    // Strobe coincident with final handshake and nothing pending.
    strobe(FA, 1);
    tick();
    tick();
    tick();
    check("s5_last_shown", px_last, 1);
    strobe(FD, 1);
    check("s5_restart_valid", px_valid, 1);
    check("s5_restart_x", px_x, 0);
    check("s5_restart_y", px_y, 0);
    wait_idle(n);
    check("s5_cycles", n, 4);
    check("s5_drop", drop_count, 1);

    // Reset in the middle of a frame.
    strobe(FF, 1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("s6_valid", px_valid, 0);
    check("s6_busy", busy, 0);
    check("s6_drop", drop_count, 0);
    check("s6_data", px_data, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s6_quiet", {px_valid, busy}, 2'b00);
    end
    strobe(FG, 1);
    wait_idle(n);
    check("s6_recover_cycles", n, 4);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
